// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ifft_pkg
// Description : Shared state encoding and sizing constants for the 4-point
//               radix-2 inverse FFT.
// Revision    : 1.0 - initial release
// ============================================================================
package ifft_pkg;

  // Frame sequencing: collect bins, two butterfly stages, stream samples
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ST1    = 2'd1,
    ST2    = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  localparam int N_PTS = 4;
  // 1/N scaling expressed as an arithmetic right shift
  localparam int LOG2N = 2;

endpackage : ifft_pkg
`default_nettype wire

// File: rtl/cbfly.sv
`default_nettype none
// ============================================================================
// Module      : cbfly
// Description : Complex radix-2 butterfly. Produces a+b and a-b at one bit of
//               growth; optionally multiplies the difference by +j, which is
//               the inverse-transform twiddle W4^-1 applied in the odd branch.
// Revision    : 1.0 - initial release
// ============================================================================
module cbfly #(
  parameter int W     = 8,
  parameter bit ROT_J = 1'b0
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W:0]   sum_re,
  output logic signed [W:0]   sum_im,
  output logic signed [W:0]   diff_re,
  output logic signed [W:0]   diff_im
);

  logic signed [W:0] ae_re, ae_im, be_re, be_im;
  logic signed [W:0] d_re, d_im;

  // Sign-extend by one bit so neither sum nor difference can wrap
  assign ae_re = {a_re[W-1], a_re};
  assign ae_im = {a_im[W-1], a_im};
  assign be_re = {b_re[W-1], b_re};
  assign be_im = {b_im[W-1], b_im};

  assign sum_re = ae_re + be_re;
  assign sum_im = ae_im + be_im;
  assign d_re   = ae_re - be_re;
  assign d_im   = ae_im - be_im;

  // j*(x + jy) = -y + jx. The difference of two W-bit values never reaches
  // -2^W, so negating it stays within W+1 bits.
  generate
    if (ROT_J) begin : g_rot_j
      assign diff_re = -d_im;
      assign diff_im = d_re;
    end else begin : g_no_rot
      assign diff_re = d_re;
      assign diff_im = d_im;
    end
  endgenerate

endmodule : cbfly
`default_nettype wire

// File: rtl/radix_2_ifft4.sv
`default_nettype none
// ============================================================================
// Module      : radix_2_ifft4
// Description : Streaming 4-point radix-2 inverse FFT. Collects four spectral
//               bins on a valid/ready input, runs two registered butterfly
//               stages, then streams four time-domain samples out.
// Revision    : 1.0 - initial release
// ============================================================================
module radix_2_ifft4
  import ifft_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter bit SCALE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W+1:0] out_re,
  output logic signed [IN_W+1:0] out_im,
  output logic [1:0]             out_idx,
  output logic                   out_last
);

  localparam int S1_W  = IN_W + 1;
  localparam int OUT_W = IN_W + 2;

  state_t state, state_nxt;
  logic [1:0] load_cnt;
  logic [1:0] idx;
  logic       in_fire;
  logic       out_fire;

  // Bin register file, natural order Y[0..3]
  logic signed [IN_W-1:0] bin_re [N_PTS];
  logic signed [IN_W-1:0] bin_im [N_PTS];

  // Stage-1 combinational results and registers
  logic signed [S1_W-1:0] s1_a0_re, s1_a0_im, s1_a1_re, s1_a1_im;
  logic signed [S1_W-1:0] s1_b0_re, s1_b0_im, s1_b1_re, s1_b1_im;
  logic signed [S1_W-1:0] a0_re, a0_im, a1_re, a1_im;
  logic signed [S1_W-1:0] b0_re, b0_im, b1_re, b1_im;

  // Stage-2 combinational results, scaled versions and output registers
  logic signed [OUT_W-1:0] s2_re [N_PTS];
  logic signed [OUT_W-1:0] s2_im [N_PTS];
  logic signed [OUT_W-1:0] sc_re [N_PTS];
  logic signed [OUT_W-1:0] sc_im [N_PTS];
  logic signed [OUT_W-1:0] x_re  [N_PTS];
  logic signed [OUT_W-1:0] x_im  [N_PTS];

  assign in_ready  = rst_n && (state == LOAD);
  assign out_valid = rst_n && (state == UNLOAD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Stage 1: even pair (Y0,Y2) plain, odd pair (Y1,Y3) with +j on the difference
  cbfly #(.W(IN_W), .ROT_J(1'b0)) u_s1_even (
    .a_re(bin_re[0]), .a_im(bin_im[0]), .b_re(bin_re[2]), .b_im(bin_im[2]),
    .sum_re(s1_a0_re), .sum_im(s1_a0_im), .diff_re(s1_a1_re), .diff_im(s1_a1_im)
  );

  cbfly #(.W(IN_W), .ROT_J(1'b1)) u_s1_odd (
    .a_re(bin_re[1]), .a_im(bin_im[1]), .b_re(bin_re[3]), .b_im(bin_im[3]),
    .sum_re(s1_b0_re), .sum_im(s1_b0_im), .diff_re(s1_b1_re), .diff_im(s1_b1_im)
  );

  // Stage 2: x0/x2 from (a0,b0), x1/x3 from (a1,b1)
  cbfly #(.W(S1_W), .ROT_J(1'b0)) u_s2_even (
    .a_re(a0_re), .a_im(a0_im), .b_re(b0_re), .b_im(b0_im),
    .sum_re(s2_re[0]), .sum_im(s2_im[0]), .diff_re(s2_re[2]), .diff_im(s2_im[2])
  );

  cbfly #(.W(S1_W), .ROT_J(1'b0)) u_s2_odd (
    .a_re(a1_re), .a_im(a1_im), .b_re(b1_re), .b_im(b1_im),
    .sum_re(s2_re[1]), .sum_im(s2_im[1]), .diff_re(s2_re[3]), .diff_im(s2_im[3])
  );

  // Optional 1/4 scaling; arithmetic shift floors toward minus infinity
  generate
    for (genvar n = 0; n < N_PTS; n++) begin : g_scale
      if (SCALE) begin : g_div
        assign sc_re[n] = s2_re[n] >>> LOG2N;
        assign sc_im[n] = s2_im[n] >>> LOG2N;
      end else begin : g_raw
        assign sc_re[n] = s2_re[n];
        assign sc_im[n] = s2_im[n];
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (load_cnt == 2'd3)) state_nxt = ST1;
      ST1:     state_nxt = ST2;
      ST2:     state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && (idx == 2'd3)) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Bin capture; the counter wraps back to 0 after the fourth bin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt <= 2'd0;
      for (int k = 0; k < N_PTS; k++) begin
        bin_re[k] <= '0;
        bin_im[k] <= '0;
      end
    end else if (in_fire) begin
      bin_re[load_cnt] <= in_re;
      bin_im[load_cnt] <= in_im;
      load_cnt         <= load_cnt + 2'd1;
    end
  end

  // Stage-1 registers, loaded once per frame in ST1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a0_re <= '0; a0_im <= '0; a1_re <= '0; a1_im <= '0;
      b0_re <= '0; b0_im <= '0; b1_re <= '0; b1_im <= '0;
    end else if (state == ST1) begin
      a0_re <= s1_a0_re; a0_im <= s1_a0_im;
      a1_re <= s1_a1_re; a1_im <= s1_a1_im;
      b0_re <= s1_b0_re; b0_im <= s1_b0_im;
      b1_re <= s1_b1_re; b1_im <= s1_b1_im;
    end
  end

  // Stage-2 (scaled) output registers, loaded once per frame in ST2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < N_PTS; n++) begin
        x_re[n] <= '0;
        x_im[n] <= '0;
      end
    end else if (state == ST2) begin
      for (int n = 0; n < N_PTS; n++) begin
        x_re[n] <= sc_re[n];
        x_im[n] <= sc_im[n];
      end
    end
  end

  // Output sample index; advances only on an accepted sample
  always_ff @(posedge clk) begin
    if (!rst_n)                  idx <= 2'd0;
    else if (state == ST2)       idx <= 2'd0;
    else if (out_fire)           idx <= idx + 2'd1;
  end

  assign out_idx  = idx;
  assign out_re   = x_re[idx];
  assign out_im   = x_im[idx];
  assign out_last = out_valid && (idx == 2'd3);

endmodule : radix_2_ifft4
`default_nettype wire

// File: tb/tb_radix_2_ifft4.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix_2_ifft4
// Description : Directed self-checking bench for radix_2_ifft4. A scaled and
//               an unscaled instance see the same stimulus; each frame is
//               checked against hand-computed inverse-FFT samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix_2_ifft4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] in_re = '0;
  logic signed [7:0] in_im = '0;

  logic              ready1, valid1, last1;
  logic signed [9:0] re1, im1;
  logic [1:0]        idx1;
  logic              ready0, valid0, last0;
  logic signed [9:0] re0, im0;
  logic [1:0]        idx0;

  int total = 0;
  int bad   = 0;
  int y_re[4], y_im[4];
  int e_re[4], e_im[4];
  int r_re[4], r_im[4];

  radix_2_ifft4 #(.IN_W(8), .SCALE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready1),
    .in_re(in_re), .in_im(in_im), .out_valid(valid1), .out_ready(out_ready),
    .out_re(re1), .out_im(im1), .out_idx(idx1), .out_last(last1)
  );

  radix_2_ifft4 #(.IN_W(8), .SCALE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready0),
    .in_re(in_re), .in_im(in_im), .out_valid(valid0), .out_ready(out_ready),
    .out_re(re0), .out_im(im0), .out_idx(idx0), .out_last(last0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present y_re/y_im as four bins; optional one-cycle gap before bin gap_at
  task automatic send(input int gap_at);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == gap_at) begin
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_re    = 8'(y_re[k]);
      in_im    = 8'(y_im[k]);
      chk("in_ready_load", ready1, 1);
      @(posedge clk);
    end
  endtask

  // Wait for the frame, check all four samples; optional stall at idx 1 and
  // optional junk input traffic while the block is busy
  task automatic recv(input bit bp, input bit junk);
    int lat;
    lat = 0;
    @(negedge clk);
    in_valid = junk;
    in_re    = 8'sd99;
    in_im    = -8'sd77;
    while (!valid1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 2);
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      chk("out_valid", valid1, 1);
      chk("out_idx", idx1, n);
      chk("out_re", re1, e_re[n]);
      chk("out_im", im1, e_im[n]);
      chk("out_last", last1, (n == 3) ? 1 : 0);
      chk("in_ready_busy", ready1, 0);
      chk("raw_idx", idx0, n);
      chk("raw_re", re0, r_re[n]);
      chk("raw_im", im0, r_im[n]);
      if (bp && n == 1) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
          chk("bp_valid", valid1, 1);
          chk("bp_idx", idx1, 1);
          chk("bp_re", re1, e_re[1]);
          chk("bp_im", im1, e_im[1]);
          chk("bp_in_ready", ready1, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_after_frame", ready1, 1);
    chk("valid_after_frame", valid1, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", ready1, 0);
      chk("rst_out_valid", valid1, 0);
    end
    chk("rst_out_re", re1, 0);
    chk("rst_out_im", im1, 0);
    chk("rst_out_idx", idx1, 0);
    chk("rst_out_last", last1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready1, 1);

    // Impulse
    y_re = '{4, 0, 0, 0};  y_im = '{0, 0, 0, 0};
    e_re = '{1, 1, 1, 1};  e_im = '{0, 0, 0, 0};
    r_re = '{4, 4, 4, 4};  r_im = '{0, 0, 0, 0};
    send(-1); recv(1'b0, 1'b0);

    // Single tone at k=1, with an input gap before bin 2
    y_re = '{0, 4, 0, 0};  y_im = '{0, 0, 0, 0};
    e_re = '{1, 0, -1, 0}; e_im = '{0, 1, 0, -1};
    r_re = '{4, 0, -4, 0}; r_im = '{0, 4, 0, -4};
    send(2); recv(1'b0, 1'b0);

    // Imaginary tone at k=3
    y_re = '{0, 0, 0, 0};  y_im = '{0, 0, 0, 4};
    e_re = '{0, 1, 0, -1}; e_im = '{1, 0, -1, 0};
    r_re = '{0, 4, 0, -4}; r_im = '{4, 0, -4, 0};
    send(-1); recv(1'b0, 1'b0);

    // Round trip of x=[1,0,1,0], with backpressure and junk inputs while busy
    y_re = '{2, 0, 2, 0};  y_im = '{0, 0, 0, 0};
    e_re = '{1, 0, 1, 0};  e_im = '{0, 0, 0, 0};
    r_re = '{4, 0, 4, 0};  r_im = '{0, 0, 0, 0};
    send(-1); recv(1'b1, 1'b1);

    // Full-scale negative input
    y_re = '{-128, -128, -128, -128}; y_im = '{0, 0, 0, 0};
    e_re = '{-128, 0, 0, 0};          e_im = '{0, 0, 0, 0};
    r_re = '{-512, 0, 0, 0};          r_im = '{0, 0, 0, 0};
    send(-1); recv(1'b0, 1'b0);

    // Floor behaviour of the scaling shift
    y_re = '{-1, 0, 0, 0};   y_im = '{1, 0, 0, 0};
    e_re = '{-1, -1, -1, -1}; e_im = '{0, 0, 0, 0};
    r_re = '{-1, -1, -1, -1}; r_im = '{1, 1, 1, 1};
    send(-1); recv(1'b0, 1'b0);

    // Reset after two bins, then a fresh frame
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = 8'sd7;
      in_im    = 8'sd7;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_out_valid", valid1, 0);
      chk("midrst_in_ready", ready1, 0);
    end
    rst_n = 1'b1;
    y_re = '{4, 4, 4, 4};  y_im = '{0, 0, 0, 0};
    e_re = '{4, 0, 0, 0};  e_im = '{0, 0, 0, 0};
    r_re = '{16, 0, 0, 0}; r_im = '{0, 0, 0, 0};
    send(-1); recv(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_radix_2_ifft4
`default_nettype wire
